// File: rtl/fp32_mac_pkg.sv
// Shared types and constants for the FP32 dot-product sequencer.
// Holds the sequencer state enum, the FP32 zero word and the default MAC latency.
package fp32_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    DONE
  } dot_state_e;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam int FP32_MAC_LAT = 5;

endpackage

// File: rtl/fp32_dot_seq_if.sv
// Operand-stream and result handshake bundle of the dot-product sequencer.
// master: operand feeder / result consumer; slave: the sequencer.
interface fp32_dot_seq_if;

  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_y;

  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_y
  );

  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_y
  );

endinterface

// File: rtl/fp32_dot_seq.sv
// Dot-product sequencer driving an accumulate-mode fp32_mac, one op in flight.
// Ports: clk, rst_n (sync, active-low), start/len job request, bus (operand
// and result handshakes), mac_* to/from the MAC, busy, err (sticky timeout).
// Optional watchdog: define FP32_DOT_SEQ_TIMEOUT_EN.
module fp32_dot_seq
  import fp32_mac_pkg::*;
#(
  parameter int MAC_LAT = FP32_MAC_LAT,
  parameter int LEN_W   = 8,
  parameter int TO_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  fp32_dot_seq_if.slave    bus,
  output logic             mac_valid_in,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [31:0]      mac_c,
  output logic             mac_use_acc,
  output logic             mac_clr_acc,
  input  logic             mac_valid_out,
  input  logic [31:0]      mac_y,
  output logic             busy,
  output logic             err
);

  if (MAC_LAT < 1 || TO_CYC < 1 || LEN_W < 1) begin : g_bad_cfg
    $error("fp32_dot_seq: invalid parameters");
  end

  dot_state_e       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             op_ready_q;
  logic             res_valid_q;
  logic [31:0]      res_y_q;
  logic             use_acc_q;
  logic             clr_q;
  logic             busy_q;

  assign cnt_nxt = cnt + LEN_W'(1);

`ifdef FP32_DOT_SEQ_TIMEOUT_EN
  // wd counts WAIT cycles including the current one
  localparam int WD_LIM = MAC_LAT + TO_CYC - 1;
  localparam int WD_W   = $clog2(WD_LIM + 1);

  logic [WD_W-1:0] wd;
  logic            err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= FP32_ZERO;
      use_acc_q   <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FP32_DOT_SEQ_TIMEOUT_EN
      wd          <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      clr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            cnt     <= '0;
            res_y_q <= FP32_ZERO;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
            state   <= CLEAR;
`ifdef FP32_DOT_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          use_acc_q <= 1'b1;
          if (len_q == '0) begin
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            op_ready_q <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.op_valid) begin
            op_ready_q <= 1'b0;
            state      <= WAIT;
`ifdef FP32_DOT_SEQ_TIMEOUT_EN
            wd         <= WD_W'(1);
`endif
          end
        end
        WAIT: begin
          if (mac_valid_out) begin
            res_y_q <= mac_y;
            cnt     <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              res_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              op_ready_q <= 1'b1;
              state      <= ISSUE;
            end
          end
`ifdef FP32_DOT_SEQ_TIMEOUT_EN
          else if (wd == WD_W'(WD_LIM)) begin
            err_q       <= 1'b1;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
`endif
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            use_acc_q   <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // op_ready_q is high exactly while in ISSUE
  assign mac_valid_in  = op_ready_q & bus.op_valid;
  assign mac_a         = bus.op_a;
  assign mac_b         = bus.op_b;
  assign mac_c         = FP32_ZERO;
  assign mac_use_acc   = use_acc_q;
  assign mac_clr_acc   = clr_q;
  assign busy          = busy_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = res_y_q;

endmodule
